// File: rtl/branch_sequencer.sv
// Branch resolution sequencer: stalls IF/ID until the compare resolves, then redirects.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BranchReq,
  input  logic [2:0]  BranchOp,
  input  logic [31:0] Target,
  input  logic        OpndReady,
  input  logic        CmpValid,
  input  logic        Zero,
  input  logic        Gt,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] PCTarget,
  output logic        Flush,
  output logic        Timeout,
  output logic [15:0] BranchCount,
  output logic [15:0] TakenCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_REDIRECT
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [31:0] r_target;
  logic [7:0]  r_cnt;
  logic        w_taken;
  logic        w_accept;
  logic        w_enter_redir;

  assign w_accept      = (r_state == S_IDLE) && BranchReq;
  assign w_enter_redir = (r_state == S_EVAL) && CmpValid && w_taken;
  assign PCTarget      = r_target;

  always_comb begin
    w_taken = 1'b0;
    unique case (r_op)
      3'd0: w_taken = Zero;
      3'd1: w_taken = !Zero;
      3'd2: w_taken = Gt;
      3'd3: w_taken = Gt | Zero;
      3'd4: w_taken = !Gt & !Zero;
      3'd5: w_taken = !Gt;
      3'd6: w_taken = 1'b1;
      3'd7: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    Stall   = 1'b0;
    PCSrc   = 1'b0;
    Flush   = 1'b0;
    Timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (BranchReq)
          w_next = OpndReady ? S_EVAL : S_WAIT;
      end
      S_WAIT: begin
        Stall = 1'b1;
        if (OpndReady)
          w_next = S_EVAL;
      end
      S_EVAL: begin
        Stall = 1'b1;
        // a late compare on the final cycle still wins over the timeout
        if (CmpValid)
          w_next = w_taken ? S_REDIRECT : S_IDLE;
        else if (r_cnt == LP_LAST) begin
          Timeout = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_REDIRECT: begin
        PCSrc  = 1'b1;
        Flush  = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 3'd0;
      r_target <= 32'd0;
      r_cnt    <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op     <= BranchOp;
        r_target <= Target;
      end
      if (r_state == S_EVAL)
        r_cnt <= r_cnt + 8'd1;
      else
        r_cnt <= 8'd0;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] r_bcnt;
  logic [15:0] r_tcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcnt <= 16'd0;
      r_tcnt <= 16'd0;
    end else begin
      if (w_accept && (r_bcnt != 16'hFFFF))
        r_bcnt <= r_bcnt + 16'd1;
      if (w_enter_redir && (r_tcnt != 16'hFFFF))
        r_tcnt <= r_tcnt + 16'd1;
    end
  end

  assign BranchCount = r_bcnt;
  assign TakenCount  = r_tcnt;
`else
  logic w_unused;
  assign w_unused    = w_enter_redir;
  assign BranchCount = 16'd0;
  assign TakenCount  = 16'd0;
`endif

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max cycles spent in EVAL awaiting CmpValid (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port BranchReq  input  1  ID-stage branch request, sampled only in IDLE.
REQ-005 SHALL have port BranchOp  input  3  condition code, latched with BranchReq.
REQ-006 SHALL have port Target  input  32  branch target, latched with BranchReq.
REQ-007 SHALL have port OpndReady  input  1  comparison operands available (no hazard).
REQ-008 SHALL have port CmpValid  input  1  Zero/Gt valid this cycle.
REQ-009 SHALL have ports Zero, Gt  input  1 each  ALU compare flags.
REQ-010 SHALL have port Stall  output  1  freeze IF/ID.
REQ-011 SHALL have port PCSrc  output  1  select PCTarget into PC.
REQ-012 SHALL have port PCTarget  output  32  redirect address.
REQ-013 SHALL have port Flush  output  1  squash IF/ID.
REQ-014 SHALL have port Timeout  output  1  one-cycle error pulse.
REQ-015 SHALL have ports BranchCount, TakenCount  output  16 each  statistics.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, EVAL, REDIRECT.
REQ-017 IDLE: BranchReq=1 SHALL latch BranchOp/Target and go to EVAL if OpndReady=1, else WAIT; BranchReq=0 stays IDLE.
REQ-018 WAIT SHALL hold until OpndReady=1, then go to EVAL next cycle; no timeout in WAIT.
REQ-019 EVAL: CmpValid=1 SHALL evaluate condition from latched BranchOp; taken -> REDIRECT, not taken -> IDLE.
REQ-020 Condition encoding: 0 BEQ Zero; 1 BNE !Zero; 2 BGT Gt; 3 BGE Gt|Zero; 4 BLT !Gt&!Zero; 5 BLE !Gt; 6 always taken; 7 never taken.
REQ-021 EVAL SHALL count cycles from 0; if CmpValid absent for TIMEOUT consecutive cycles, Timeout=1 for one cycle and FSM returns IDLE with no redirect.
REQ-022 REDIRECT SHALL last exactly one cycle with PCSrc=1, Flush=1, PCTarget=latched Target, then IDLE.
REQ-023 PCSrc and Flush SHALL be 0 in all other states; PCTarget holds last latched Target.
REQ-024 Stall SHALL be 1 in WAIT and EVAL, 0 in IDLE and REDIRECT.
REQ-025 Best-case latency: BranchReq (IDLE) -> EVAL next cycle; CmpValid same EVAL cycle -> PCSrc next cycle (2 cycles request to redirect).
REQ-026 BranchReq outside IDLE SHALL be ignored (no latch, no count).
REQ-027 CmpValid arriving on the same cycle the counter reaches TIMEOUT SHALL take priority over Timeout.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE from any state, including mid-branch, discarding latched op.
REQ-029 After reset: Stall=0, PCSrc=0, Flush=0, Timeout=0, PCTarget=0, BranchCount=0, TakenCount=0, timeout counter=0.
REQ-030 reset SHALL dominate BranchReq in the same cycle.

Configuration
REQ-031 Macro BRANCH_STATS_EN defined: BranchCount SHALL increment on every accepted BranchReq and TakenCount on every REDIRECT entry, both saturating at 16'hFFFF.
REQ-032 BRANCH_STATS_EN undefined: counters SHALL not be built and both ports SHALL be constant 0.

Verification
REQ-033 BranchOp=0, OpndReady=1, CmpValid=1 with Zero=1 in EVAL, Target=32'h0040_0020 -> PCSrc=Flush=1 exactly one cycle, PCTarget=32'h0040_0020, Stall=1 one cycle.
REQ-034 All 8 BranchOp x 4 Zero/Gt combos -> taken/not-taken matches REQ-020 table; not-taken yields no PCSrc pulse.
REQ-035 OpndReady=0 for 3 cycles after BranchReq -> Stall=1 for 3 WAIT cycles plus EVAL cycles; then normal resolve.
REQ-036 CmpValid held 0 in EVAL -> Timeout=1 on TIMEOUT-th cycle (15 default), IDLE next, PCSrc never 1; CmpValid on that same cycle -> resolve, Timeout=0.
REQ-037 reset asserted in EVAL and in WAIT -> next cycle all outputs at REQ-029 values; subsequent BranchReq accepted normally.
REQ-038 With BRANCH_STATS_EN: 3 branches (2 taken) -> BranchCount=3, TakenCount=2; BranchReq pulses during Stall not counted; without macro both read 0.
